// File: rtl/redpitaya_pll_lock_supervisor.sv
// Converter PLL supervisor in the adc_clk domain: pulses PLL RST, debounces LOCKED,
// then releases the DAC-path and DSP-path resets in order; counts lock losses.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   PLL_RST   | pll_rst_o held high for PLL_RST_CYCLES
//   WAIT_LOCK | waiting for synced LOCKED, re-pulse RST after LOCK_TIMEOUT
//   STABILIZE | LOCKED must stay high LOCK_STABLE_CYCLES in a row
//   RELEASE   | DAC path out of reset, DSP path follows after STAGE_GAP
//   RUN       | fully released, locked_o high
//   LOST      | one-cycle loss marker, resets reasserted, stats updated
module redpitaya_pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES     = 8,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int STAGE_GAP          = 16,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                 adc_clk_i,
    input  logic                 adc_rstn_i,
    input  logic                 pll_locked_i,
    input  logic                 clear_i,
    output logic                 pll_rst_o,
    output logic                 dac_rstn_o,
    output logic                 dsp_rstn_o,
    output logic                 locked_o,
    output logic                 unlock_sticky_o,
    output logic [CNT_WIDTH-1:0] unlock_cnt_o,
    output logic [2:0]           state_o
);

    localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_CD = (LOCK_TIMEOUT > STAGE_GAP) ? LOCK_TIMEOUT : STAGE_GAP;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int TW     = $clog2(MAX_P) + 1;

    localparam logic [TW-1:0] TC_RST     = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TC_TIMEOUT = TW'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that first saw lock counts toward the stable run.
    localparam logic [TW-1:0] TC_STABLE  = TW'(LOCK_STABLE_CYCLES - 2);
    localparam logic [TW-1:0] TC_GAP     = TW'(STAGE_GAP - 1);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABILIZE = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_LOST      = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_tmr;
    logic          w_loss;

    (* ASYNC_REG = "TRUE" *) logic r_lk_meta;
    (* ASYNC_REG = "TRUE" *) logic r_lk_sync;

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            r_lk_meta <= 1'b0;
            r_lk_sync <= 1'b0;
        end else begin
            r_lk_meta <= pll_locked_i;
            r_lk_sync <= r_lk_meta;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_PLL_RST:   if (r_tmr == TC_RST) w_next = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (r_lk_sync)                 w_next = S_STABILIZE;
                else if (r_tmr == TC_TIMEOUT)  w_next = S_PLL_RST;
            end
            S_STABILIZE: begin
                if (!r_lk_sync)                w_next = S_WAIT_LOCK;
                else if (r_tmr == TC_STABLE)   w_next = S_RELEASE;
            end
            S_RELEASE: begin
                if (!r_lk_sync)                w_next = S_LOST;
                else if (r_tmr == TC_GAP)      w_next = S_RUN;
            end
            S_RUN:       if (!r_lk_sync) w_next = S_LOST;
            S_LOST:      w_next = S_PLL_RST;
            default:     w_next = S_PLL_RST;
        endcase
    end

    assign w_loss  = (w_next == S_LOST);
    assign state_o = r_state;

    // Outputs are registered from the next state so they move together with state_o.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            r_state         <= S_PLL_RST;
            r_tmr           <= '0;
            pll_rst_o       <= 1'b1;
            dac_rstn_o      <= 1'b0;
            dsp_rstn_o      <= 1'b0;
            locked_o        <= 1'b0;
            unlock_sticky_o <= 1'b0;
            unlock_cnt_o    <= '0;
        end else begin
            r_state    <= w_next;
            r_tmr      <= (w_next != r_state) ? '0 : r_tmr + 1'b1;
            pll_rst_o  <= (w_next == S_PLL_RST);
            dac_rstn_o <= (w_next == S_RELEASE) || (w_next == S_RUN);
            dsp_rstn_o <= (w_next == S_RUN);
            locked_o   <= (w_next == S_RUN);
            if (w_loss) begin
                unlock_sticky_o <= 1'b1;
                if (unlock_cnt_o != {CNT_WIDTH{1'b1}})
                    unlock_cnt_o <= unlock_cnt_o + CNT_WIDTH'(1);
            end else if (clear_i) begin
                unlock_sticky_o <= 1'b0;
                unlock_cnt_o    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_redpitaya_pll_lock_supervisor.sv
// Bench for redpitaya_pll_lock_supervisor: directed lock scenarios plus random lock/clear/reset
// traffic, all cycles scored against a phase/duration reference model through a queue.
module tb_redpitaya_pll_lock_supervisor;

    localparam int P_RST    = 8;
    localparam int P_STABLE = 16;
    localparam int P_TO     = 64;
    localparam int P_GAP    = 4;
    localparam int P_CW     = 4;
    localparam int CNT_MAX  = (1 << P_CW) - 1;

    logic            adc_clk_i = 1'b0;
    logic            adc_rstn_i;
    logic            pll_locked_i = 1'b0;
    logic            clear_i = 1'b0;
    logic            pll_rst_o;
    logic            dac_rstn_o;
    logic            dsp_rstn_o;
    logic            locked_o;
    logic            unlock_sticky_o;
    logic [P_CW-1:0] unlock_cnt_o;
    logic [2:0]      state_o;

    redpitaya_pll_lock_supervisor #(
        .PLL_RST_CYCLES    (P_RST),
        .LOCK_STABLE_CYCLES(P_STABLE),
        .LOCK_TIMEOUT      (P_TO),
        .STAGE_GAP         (P_GAP),
        .CNT_WIDTH         (P_CW)
    ) dut (
        .adc_clk_i      (adc_clk_i),
        .adc_rstn_i     (adc_rstn_i),
        .pll_locked_i   (pll_locked_i),
        .clear_i        (clear_i),
        .pll_rst_o      (pll_rst_o),
        .dac_rstn_o     (dac_rstn_o),
        .dsp_rstn_o     (dsp_rstn_o),
        .locked_o       (locked_o),
        .unlock_sticky_o(unlock_sticky_o),
        .unlock_cnt_o   (unlock_cnt_o),
        .state_o        (state_o)
    );

    always #5 adc_clk_i = ~adc_clk_i;

    typedef struct {
        logic [11:0] v;
        int          n;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          tick_no = 0;
    logic [11:0] obs;

    assign obs = {pll_rst_o, dac_rstn_o, dsp_rstn_o, locked_o, unlock_sticky_o, unlock_cnt_o, state_o};

    // Reference model: phase number (as published on state_o), cycles spent in phase,
    // consecutive synced-lock run since WAIT_LOCK, 2-cycle lock delay line, stats.
    int   m_ph, m_age, m_run, m_cnt;
    logic m_sticky, m_s1, m_s2;

    task automatic m_reset();
        m_ph = 0; m_age = 0; m_run = 0; m_cnt = 0;
        m_sticky = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
    endtask

    function automatic logic [11:0] m_out();
        logic pr, da, ds, lk;
        pr = (m_ph == 0);
        da = (m_ph == 3) || (m_ph == 4);
        ds = (m_ph == 4);
        lk = (m_ph == 4);
        return {pr, da, ds, lk, m_sticky, 4'(m_cnt), 3'(m_ph)};
    endfunction

    task automatic m_step(input logic pin, input logic clr);
        int   nph, run_now;
        logic lk;
        lk      = m_s2;
        nph     = m_ph;
        run_now = (lk && (m_ph == 1 || m_ph == 2)) ? m_run + 1 : 0;
        case (m_ph)
            0: if (m_age + 1 >= P_RST) nph = 1;
            1: if (lk) nph = 2; else if (m_age + 1 >= P_TO) nph = 0;
            2: if (!lk) nph = 1; else if (run_now >= P_STABLE) nph = 3;
            3: if (!lk) nph = 5; else if (m_age + 1 >= P_GAP) nph = 4;
            4: if (!lk) nph = 5;
            default: nph = 0;
        endcase
        if (nph == 5) begin
            m_sticky = 1'b1;
            if (m_cnt < CNT_MAX) m_cnt++;
        end else if (clr) begin
            m_sticky = 1'b0;
            m_cnt    = 0;
        end
        m_run = run_now;
        m_age = (nph == m_ph) ? m_age + 1 : 0;
        m_ph  = nph;
        m_s2  = m_s1;
        m_s1  = pin;
    endtask

    // One clock: drive inputs just after the edge, queue the model's view of this cycle.
    task automatic tick(input logic lk, input logic clr, input logic rn);
        exp_t e;
        @(posedge adc_clk_i);
        #1;
        pll_locked_i = lk;
        clear_i      = clr;
        adc_rstn_i   = rn;
        if (!rn) m_reset();
        e.v = m_out();
        e.n = tick_no;
        sb.push_back(e);
        if (rn) m_step(lk, clr);
        tick_no++;
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge adc_clk_i);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (obs !== e.v) begin
                    bad++;
                    $display("FAIL scoreboard tick=%0d got=%h want=%h", e.n, obs, e.v);
                end
            end
        end
    end

    initial begin : driver
        int   n, pr, last_rise, nrise, rstn_seen, dac_first, dsp_first, lck_first, hi_cnt, lo_first, left;
        logic prev, lk;

        m_reset();
        adc_rstn_i = 1'b1;
        #2 adc_rstn_i = 1'b0;
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        chk("reset_state", state_o, 0);
        chk("reset_pll_rst", pll_rst_o, 1);
        chk("reset_dac_rstn", dac_rstn_o, 0);

        // Lock never arrives: periodic PLL RST re-pulse, nothing released.
        prev = 1'b1; last_rise = -1; nrise = 0; rstn_seen = 0;
        for (int c = 0; c < 300; c++) begin
            tick(1'b0, 1'b0, 1'b1);
            if (pll_rst_o && !prev) begin
                if (last_rise >= 0) chk("repulse_period", c - last_rise, P_RST + P_TO);
                else                chk("first_repulse", c, P_RST + P_TO);
                last_rise = c;
                nrise++;
            end
            prev = pll_rst_o;
            if (dac_rstn_o || dsp_rstn_o) rstn_seen++;
        end
        chk("repulse_count", nrise, 4);
        chk("rstn_stuck_low", rstn_seen, 0);
        chk("no_lock_cnt", unlock_cnt_o, 0);

        // Lock arrives with a 3-cycle glitch inside STABILIZE.
        dac_first = -1;
        for (int j = 0; j < 40; j++) begin
            tick(!(j >= 8 && j < 11), 1'b0, 1'b1);
            if (j == 9)  chk("glitch_in_stabilize", state_o, 2);
            if (j == 11) chk("glitch_back_to_wait", state_o, 1);
            if (dac_rstn_o && dac_first < 0) dac_first = j;
        end
        chk("glitch_dac_rise", dac_first, 11 + 2 + P_STABLE);
        chk("glitch_cnt", unlock_cnt_o, 0);
        chk("glitch_sticky", unlock_sticky_o, 0);
        chk("glitch_locked", locked_o, 1);

        // Fresh start, lock raised at cycle 20.
        repeat (2) tick(1'b0, 1'b0, 1'b0);
        dac_first = -1; dsp_first = -1; lck_first = -1; hi_cnt = 0; lo_first = -1;
        for (int c = 0; c < 60; c++) begin
            tick(c >= 20, 1'b0, 1'b1);
            if (dac_rstn_o && dac_first < 0) dac_first = c;
            if (dsp_rstn_o && dsp_first < 0) dsp_first = c;
            if (locked_o && lck_first < 0)   lck_first = c;
            if (pll_rst_o) hi_cnt++;
            if (!pll_rst_o && lo_first < 0)  lo_first = c;
        end
        chk("boot_pll_rst_len", hi_cnt, P_RST);
        chk("boot_pll_rst_fall", lo_first, P_RST);
        chk("boot_dac_rise", dac_first, 20 + 2 + P_STABLE);
        chk("boot_dsp_rise", dsp_first, 20 + 2 + P_STABLE + P_GAP);
        chk("boot_locked_rise", lck_first, 20 + 2 + P_STABLE + P_GAP);

        // Seventeen lock drops from RUN: counter saturates.
        for (int i = 0; i < 17; i++) begin
            pr = 0;
            repeat (20) begin
                tick(1'b0, 1'b0, 1'b1);
                pr += int'(pll_rst_o);
            end
            n = 0;
            while (!locked_o && n < 80) begin
                tick(1'b1, 1'b0, 1'b1);
                pr += int'(pll_rst_o);
                n++;
            end
            chk("drop_relock", locked_o, 1);
            chk("drop_pll_rst_len", pr, P_RST);
            chk("drop_cnt", unlock_cnt_o, (i + 1 > CNT_MAX) ? CNT_MAX : i + 1);
        end
        chk("drop_sticky", unlock_sticky_o, 1);

        // Clear alone, then clear coincident with a loss, then clear alone right after.
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        chk("clear_cnt", unlock_cnt_o, 0);
        chk("clear_sticky", unlock_sticky_o, 0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        chk("clear_vs_loss_state", state_o, 5);
        chk("clear_vs_loss_cnt", unlock_cnt_o, 1);
        chk("clear_vs_loss_sticky", unlock_sticky_o, 1);
        tick(1'b0, 1'b0, 1'b1);
        chk("clear_after_cnt", unlock_cnt_o, 0);
        chk("clear_after_sticky", unlock_sticky_o, 0);
        repeat (16) tick(1'b0, 1'b0, 1'b1);

        // Reset asserted in RELEASE, then clean restart with lock already present.
        n = 0;
        while (state_o != 3'd3 && n < 80) begin
            tick(1'b1, 1'b0, 1'b1);
            n++;
        end
        chk("reach_release", state_o, 3);
        tick(1'b1, 1'b0, 1'b0);
        chk("rst_mid_state", state_o, 0);
        chk("rst_mid_pll_rst", pll_rst_o, 1);
        chk("rst_mid_dac", dac_rstn_o, 0);
        chk("rst_mid_cnt", unlock_cnt_o, 0);
        tick(1'b1, 1'b0, 1'b0);
        dac_first = -1; lck_first = -1;
        for (int c = 0; c < 40; c++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (dac_rstn_o && dac_first < 0) dac_first = c;
            if (locked_o && lck_first < 0)   lck_first = c;
        end
        chk("restart_dac_rise", dac_first, P_RST + P_STABLE);
        chk("restart_locked_rise", lck_first, P_RST + P_STABLE + P_GAP);

        // Random lock dropouts, clear pulses and occasional resets.
        lk = 1'b1; left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (left == 0) begin
                lk   = ~lk;
                left = lk ? $urandom_range(10, 120) : $urandom_range(1, 30);
            end
            left--;
            tick(lk, ($urandom_range(0, 31) == 0), ($urandom_range(0, 999) != 0));
        end

        repeat (2) tick(1'b1, 1'b0, 1'b1);
        @(negedge adc_clk_i);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
